// File: rtl/sliding_window_pkg.sv
// rtl/sliding_window_pkg.sv - shared helpers for the sliding-window line buffer
package sliding_window_pkg;

  // Counter width for a dimension of n positions; never narrower than one bit.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sliding_window_if.sv
// rtl/sliding_window_if.sv - pixel-in / window-out bundle of the sliding-window generator
interface sliding_window_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3
);
  logic [DATA_WIDTH-1:0] inputPixel;
  logic [DATA_WIDTH-1:0] window [KERNEL_DIM-1:0][KERNEL_DIM-1:0];
  logic                  valid;

  modport master (output inputPixel, input window, input valid);
  modport slave  (input inputPixel, output window, output valid);
endinterface

// File: rtl/sliding_window_raster_pos_counter.sv
// rtl/sliding_window_raster_pos_counter.sv - raster row/col position of the next incoming pixel
module raster_pos_counter
  import sliding_window_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int HEIGHT = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [pos_width(HEIGHT)-1:0] row,
  output logic [pos_width(WIDTH)-1:0]  col
);
  localparam int COL_W = pos_width(WIDTH);
  localparam int ROW_W = pos_width(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end else begin
      col <= col + COL_W'(1);
    end
  end
endmodule

// File: rtl/sliding_window.sv
// rtl/sliding_window.sv - K x K sliding-window line buffer over a square raster image
module sliding_window
  import sliding_window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int ROW_SIZE   = 5
) (
  input logic            clk,
  input logic            rst,
  sliding_window_if.slave px
);
  localparam int BUFFER_SIZE = (KERNEL_DIM - 1) * ROW_SIZE + KERNEL_DIM;
  localparam int POS_W       = pos_width(ROW_SIZE);
  localparam logic [POS_W-1:0] FIRST_FULL = POS_W'(KERNEL_DIM - 1);

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  if (KERNEL_DIM < 1 || KERNEL_DIM > ROW_SIZE) begin : g_bad_kernel
    $fatal(1, "sliding_window: KERNEL_DIM must lie in 1..ROW_SIZE");
  end

  pixel_t           buffer [0:BUFFER_SIZE-1];
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;
  logic             valid_q;

  raster_pos_counter #(
    .WIDTH  (ROW_SIZE),
    .HEIGHT (ROW_SIZE)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .row (row),
    .col (col)
  );

  // valid is judged on the position of the pixel being accepted, so it lines up
  // with the window that appears after the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) buffer[i] <= '0;
      valid_q <= 1'b0;
    end else begin
      buffer[0] <= px.inputPixel;
      for (int i = 1; i < BUFFER_SIZE; i++) buffer[i] <= buffer[i-1];
      valid_q <= (row >= FIRST_FULL) && (col >= FIRST_FULL);
    end
  end

  assign px.valid = valid_q;

  // Row 0 of the window is the oldest image row, col 0 the leftmost pixel.
  for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_row
    for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_col
      assign px.window[r][c] = buffer[(KERNEL_DIM-1-r)*ROW_SIZE + (KERNEL_DIM-1-c)];
    end
  end
endmodule

// File: tb/tb_sliding_window.sv
// tb/tb_sliding_window.sv - self-checking bench for sliding_window
module tb_sliding_window;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sliding_window_if #(.DATA_WIDTH(8), .KERNEL_DIM(3)) if_main ();
  sliding_window_if #(.DATA_WIDTH(8), .KERNEL_DIM(1)) if_k1 ();
  sliding_window_if #(.DATA_WIDTH(8), .KERNEL_DIM(4)) if_k4 ();

  sliding_window #(.DATA_WIDTH(8), .KERNEL_DIM(3), .ROW_SIZE(5)) u_main (
    .clk (clk), .rst (rst), .px (if_main));
  sliding_window #(.DATA_WIDTH(8), .KERNEL_DIM(1), .ROW_SIZE(4)) u_k1 (
    .clk (clk), .rst (rst), .px (if_k1));
  sliding_window #(.DATA_WIDTH(8), .KERNEL_DIM(4), .ROW_SIZE(4)) u_k4 (
    .clk (clk), .rst (rst), .px (if_k4));

  int rsz [3] = '{5, 4, 4};
  int kdim [3] = '{3, 1, 4};

  int total = 0;
  int bad   = 0;

  // Reference model: pixel history (newest first) and the current frame as a 2-D image.
  int hist [3][32];
  int img  [3][5][5];
  int cnt  [3];
  bit ev   [3];
  int er   [3];
  int ec   [3];
  bit fe   [3];
  int vtally [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; ev[i] = 1'b0; fe[i] = 1'b0; vtally[i] = 0;
      for (int j = 0; j < 32; j++) hist[i][j] = 0;
    end
  endtask

  task automatic model_accept(input int pix);
    for (int i = 0; i < 3; i++) begin
      int pos, r, c;
      pos = cnt[i] % (rsz[i] * rsz[i]);
      r = pos / rsz[i];
      c = pos % rsz[i];
      img[i][r][c] = pix;
      ev[i] = (r >= kdim[i] - 1) && (c >= kdim[i] - 1);
      er[i] = r;
      ec[i] = c;
      fe[i] = (pos == rsz[i] * rsz[i] - 1);
      for (int j = 31; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = pix;
      cnt[i]++;
    end
  endtask

  // Valid windows are the image patch ending at the current pixel; otherwise the raw taps.
  function automatic int expect_win(input int i, input int r, input int c);
    int k;
    k = kdim[i];
    if (ev[i]) return img[i][er[i] - (k - 1) + r][ec[i] - (k - 1) + c];
    return hist[i][(k - 1 - r) * rsz[i] + (k - 1 - c)];
  endfunction

  task automatic check_all();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("main_win[%0d][%0d]", r, c), 32'(if_main.window[r][c]), expect_win(0, r, c));
    chk("main_valid", 32'(if_main.valid), 32'(ev[0]));
    chk("k1_win", 32'(if_k1.window[0][0]), expect_win(1, 0, 0));
    chk("k1_valid", 32'(if_k1.valid), 32'(ev[1]));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("k4_win[%0d][%0d]", r, c), 32'(if_k4.window[r][c]), expect_win(2, r, c));
    chk("k4_valid", 32'(if_k4.valid), 32'(ev[2]));
    if (if_main.valid === 1'b1) vtally[0]++;
    if (if_k1.valid === 1'b1) vtally[1]++;
    if (if_k4.valid === 1'b1) vtally[2]++;
    for (int i = 0; i < 3; i++) begin
      if (fe[i]) begin
        chk($sformatf("frame_valid_count_%0d", i), vtally[i],
            (rsz[i] - kdim[i] + 1) * (rsz[i] - kdim[i] + 1));
        vtally[i] = 0;
      end
    end
  endtask

  task automatic check_buffers_zero(input string tag);
    for (int j = 0; j < u_main.BUFFER_SIZE; j++)
      chk($sformatf("%s_main_buf[%0d]", tag, j), 32'(u_main.buffer[j]), 0);
    for (int j = 0; j < u_k4.BUFFER_SIZE; j++)
      chk($sformatf("%s_k4_buf[%0d]", tag, j), 32'(u_k4.buffer[j]), 0);
  endtask

  task automatic step(input int pix);
    if_main.inputPixel = 8'(pix);
    if_k1.inputPixel   = 8'(pix);
    if_k4.inputPixel   = 8'(pix);
    @(posedge clk);
    model_accept(pix);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    if_main.inputPixel = '0;
    if_k1.inputPixel   = '0;
    if_k4.inputPixel   = '0;
    model_reset();
    @(negedge clk);
    check_all();
    check_buffers_zero("reset");
    rst = 1'b1;

    // Frame 1: ramp 1..25
    for (int p = 1; p <= 25; p++) begin
      step(p);
      if (p == 12) chk("p12_valid", 32'(if_main.valid), 0);
      if (p == 13) begin
        chk("p13_valid", 32'(if_main.valid), 1);
        chk("p13_w00", 32'(if_main.window[0][0]), 1);
        chk("p13_w11", 32'(if_main.window[1][1]), 7);
        chk("p13_w22", 32'(if_main.window[2][2]), 13);
      end
      if (p == 16) begin
        chk("p16_main_valid", 32'(if_main.valid), 0);
        chk("p16_k4_valid", 32'(if_k4.valid), 1);
        chk("p16_k4_w00", 32'(if_k4.window[0][0]), 1);
        chk("p16_k4_w33", 32'(if_k4.window[3][3]), 16);
      end
      if (p == 18) chk("p18_w00", 32'(if_main.window[0][0]), 6);
      if (p == 25) begin
        chk("p25_valid", 32'(if_main.valid), 1);
        chk("p25_w00", 32'(if_main.window[0][0]), 13);
      end
    end

    // Frame wrap with the input held, then the rest of frame 2 random
    step(25);
    chk("wrap_valid", 32'(if_main.valid), 0);
    chk("wrap_w22", 32'(if_main.window[2][2]), 25);
    chk("wrap_buf0", 32'(u_main.buffer[0]), 25);
    chk("wrap_buf12", 32'(u_main.buffer[12]), 14);
    for (int p = 0; p < 24; p++) step(int'($urandom_range(0, 255)));

    // Frame 3 cut short by an asynchronous reset between edges
    for (int p = 0; p < 20; p++) step(int'($urandom_range(0, 255)));
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    check_buffers_zero("midreset");
    @(negedge clk);
    rst = 1'b1;

    for (int p = 1; p <= 25; p++) begin
      step(p);
      if (p == 12) chk("re_p12_valid", 32'(if_main.valid), 0);
      if (p == 13) chk("re_p13_w00", 32'(if_main.window[0][0]), 1);
    end

    for (int p = 0; p < 75; p++) step(int'($urandom_range(0, 255)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sliding_window.md
Name: sliding_window

Overview:
- Streaming K×K sliding-window generator (line buffer) for a square ROW_SIZE×ROW_SIZE raster image, one pixel per clock.
- Sits in the max-pooling path ahead of the pooling/compare stage.
- Exposes the current K×K neighbourhood in parallel, plus a flag marking windows that lie fully inside the image.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- KERNEL_DIM, 3, window edge K. Legal range is 1 ≤ KERNEL_DIM ≤ ROW_SIZE; elaboration fails outside it.
- ROW_SIZE, 5, image width and height in pixels (square image).
- BUFFER_SIZE, localparam, (KERNEL_DIM-1)*ROW_SIZE + KERNEL_DIM, shift-register depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- inputPixel  in  DATA_WIDTH  raster-order pixel, consumed every clock while rst=1.
- window  out  unpacked [KERNEL_DIM-1:0][KERNEL_DIM-1:0] × DATA_WIDTH  current neighbourhood; [row][col], row 0 = oldest image row, col 0 = leftmost.
- valid  out  1  window is a complete, non-wrapping K×K image patch.

Behaviour:
- Storage is an internal array named `buffer[0:BUFFER_SIZE-1]`, DATA_WIDTH each. Both `buffer` and `BUFFER_SIZE` keep these names, because benches probe them hierarchically.
- Every rising edge with rst=1:
  - buffer[0] <= inputPixel;
  - buffer[i] <= buffer[i-1] for i = 1..BUFFER_SIZE-1.
- There is no input handshake; a pixel is taken every cycle.
- window[r][c] = buffer[(K-1-r)*ROW_SIZE + (K-1-c)]. This is combinational from `buffer`, so window[K-1][K-1] is the pixel accepted at the last edge.
- Latency: a pixel accepted at edge N is visible in window[K-1][K-1] right after edge N.
- Position tracking: col and row counters (each $clog2(ROW_SIZE) bits) hold the raster position of the next incoming pixel.
  - col increments every cycle and wraps ROW_SIZE-1 → 0.
  - On that wrap, row increments and wraps ROW_SIZE-1 → 0 (frame boundary); the next frame starts immediately.
- valid is a register updated on the same edge as the buffer: valid <= (row ≥ K-1) && (col ≥ K-1), evaluated on the position of the pixel being accepted. valid therefore describes exactly the window shown after that edge.
- Windows that straddle a row edge or a frame edge give valid=0. Their window contents are don't-care for consumers but remain the deterministic shift-register taps.
- Per full frame: (ROW_SIZE-K+1)^2 valid cycles.
- Reset (rst=0, asynchronous): all buffer entries, and therefore every window element, go to 0; valid=0, row=0, col=0.
- Reset mid-frame: same as above. The first pixel after release is treated as row 0, col 0, and valid stays 0 until K-1 full rows plus K pixels have been re-accepted.
- K=1 case: BUFFER_SIZE=1 and valid=1 on every cycle after the first accepted pixel.
- inputPixel is sampled only at rising edges; changes between edges have no effect.

Decomposition:
- No shared package is needed. Pixel width is a module parameter; a local typedef pixel_t = logic [DATA_WIDTH-1:0] is optional.
- One natural sub-module: raster_pos_counter (params WIDTH=ROW_SIZE, HEIGHT=ROW_SIZE; outputs row, col; async active-low reset).
- The shift register and window tap mapping stay in the top module.

Test Plan:
- Reset → window all 0, valid=0, buffer all 0; then assert rst=0 mid-stream → same values immediately, without waiting for a clock edge.
- 5×5 image, K=3, pixels 1..25 from reset release:
  - after pixel 12, valid=0;
  - after pixel 13, valid=1, window = [1 2 3 / 6 7 8 / 11 12 13];
  - after pixels 14 and 15, valid=1, windows [2 3 4 / 7 8 9 / 12 13 14] and [3 4 5 / 8 9 10 / 13 14 15].
- Row-edge suppression, same stream:
  - after pixels 16 and 17, valid=0;
  - after pixel 18, valid=1, window [6 7 8 / 11 12 13 / 16 17 18];
  - after pixel 25, valid=1, window [13 14 15 / 18 19 20 / 23 24 25]; exactly 9 valid cycles in the frame.
- Frame wrap: a 26th clock with inputPixel held at 25 → valid=0, window[2][2]=25, buffer[0]=25, buffer[12]=14. A second full frame yields 9 valid windows again.
- Mid-frame reset after pixel 20, then restart with pixels 1..25 → no valid until the new pixel 13, then the same results as the first frame.
- Parameter sweep (K=1, ROW_SIZE=4; K=4, ROW_SIZE=4) → valid count per frame = (ROW_SIZE-K+1)^2; K=4 is valid only on pixel 16, with window rows 1..4 / 5..8 / 9..12 / 13..16.
